ts_sched: RTL and testbench

// - Transmit scheduler directly downstream of the metadata buffer.
// - Picks one of four metadata queues per transmission: q0 even-slot TSN, q1 odd-slot TSN,
//   q2 bandwidth-reservation/PTP (token-bucket shaped), q3 best effort.
// - Issues the one-cycle read enable, captures the 8-bit metadata returned one cycle later,

---
 rtl/ts_pkg.sv | 40 ++++
 rtl/ts_token_bucket.sv | 43 ++++
 rtl/ts_sched.sv | 144 ++++++++++++++
 tb/tb_ts_sched.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared types and helpers for the transmit scheduler: FSM states, queue ids,
// and the metadata beat forwarded to the output-port stage.
package ts_pkg;

  localparam int unsigned NUM_Q = 4;
  localparam int unsigned QID_W = 2;
  localparam int unsigned MD_W  = 8;
  localparam int unsigned LEN_W = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_MD = 2'd1,
    BUSY    = 2'd2
  } ts_state_e;

  typedef logic [QID_W-1:0] qid_t;

  localparam qid_t Q_EVEN = QID_W'(0);
  localparam qid_t Q_ODD  = QID_W'(1);
  localparam qid_t Q_RSV  = QID_W'(2);
  localparam qid_t Q_BE   = QID_W'(3);

  typedef struct packed {
    logic [MD_W-1:0] md;
    qid_t            qid;
  } md_beat_t;

  // Fixed priority: lowest queue index wins.
  function automatic qid_t pick_queue(input logic [NUM_Q-1:0] elig);
    if (elig[Q_EVEN])     pick_queue = Q_EVEN;
    else if (elig[Q_ODD]) pick_queue = Q_ODD;
    else if (elig[Q_RSV]) pick_queue = Q_RSV;
    else                  pick_queue = Q_BE;
  endfunction

  function automatic logic [NUM_Q-1:0] qid_onehot(input qid_t q);
    qid_onehot = NUM_Q'(1) << q;
  endfunction

endpackage

// File: rtl/ts_token_bucket.sv
// Token bucket shaping the reservation queue: accrues TOKEN_RATE per clock up to
// TOKEN_MAX and charges the packet length when that queue is selected.
module ts_token_bucket
  import ts_pkg::*;
#(
  parameter int unsigned TOKEN_W    = 16,
  parameter int unsigned TOKEN_RATE = 1,
  parameter int unsigned TOKEN_MAX  = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             deduct_en,
  input  logic [LEN_W-1:0] deduct_len,
  input  logic [LEN_W-1:0] len,
  output logic             eligible
);

  localparam int unsigned SUM_W = TOKEN_W + 1;

  logic [TOKEN_W-1:0] tokens;
  logic [TOKEN_W-1:0] tokens_d;
  logic [SUM_W-1:0]   deduct_c;
  logic [SUM_W-1:0]   sum_c;

  // One guard bit so the saturation compare sees the true sum; a charge never
  // exceeds the balance, so the subtraction cannot go negative.
  always_comb begin
    deduct_c = deduct_en ? SUM_W'(deduct_len) : '0;
    sum_c    = SUM_W'(tokens) + SUM_W'(TOKEN_RATE) - deduct_c;
    tokens_d = (sum_c > SUM_W'(TOKEN_MAX)) ? TOKEN_W'(TOKEN_MAX) : sum_c[TOKEN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tokens <= '0;
    end else begin
      tokens <= tokens_d;
    end
  end

  assign eligible = (tokens >= TOKEN_W'(len));

endmodule

// File: rtl/ts_sched.sv
// Transmit scheduler: arbitrates four metadata queues, issues the buffer read,
// forwards the returned metadata and holds until the output port finishes.
module ts_sched
  import ts_pkg::*;
#(
  parameter int unsigned TOKEN_W    = 16,
  parameter int unsigned TOKEN_RATE = 1,
  parameter int unsigned TOKEN_MAX  = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_Q-1:0] in_ts_fifo_empty,
  input  logic [LEN_W-1:0] in_ts_pkt_len,
  input  logic [NUM_Q-1:0] in_ts_gate_open,
  input  logic             in_ts_slot_odd,
  output logic             out_ts_q0_rden,
  output logic             out_ts_q1_rden,
  output logic             out_ts_q2_rden,
  output logic             out_ts_q3_rden,
  input  logic [MD_W-1:0]  in_ts_md,
  input  logic             in_ts_md_wr,
  output logic [MD_W-1:0]  out_ts_md,
  output logic             out_ts_md_wr,
  output logic [QID_W-1:0] out_ts_qid,
  input  logic             in_ts_tx_done,
  output logic             out_ts_busy,
  output logic             out_ts_err
);

  ts_state_e        state_q, state_d;
  logic [NUM_Q-1:0] rden_q, rden_d;
  md_beat_t         beat_q, beat_d;
  logic             md_wr_q, md_wr_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [NUM_Q-1:0] elig_c;
  qid_t             pick_c;
  logic             rsv_ok_c;
  logic             deduct_en_c;

  ts_token_bucket #(
    .TOKEN_W    (TOKEN_W),
    .TOKEN_RATE (TOKEN_RATE),
    .TOKEN_MAX  (TOKEN_MAX)
  ) u_bucket (
    .clk        (clk),
    .rst_n      (rst_n),
    .deduct_en  (deduct_en_c),
    .deduct_len (in_ts_pkt_len),
    .len        (in_ts_pkt_len),
    .eligible   (rsv_ok_c)
  );

  // Per-queue eligibility; only consumed while idle.
  always_comb begin
    elig_c         = '0;
    elig_c[Q_EVEN] = ~in_ts_fifo_empty[Q_EVEN] & in_ts_gate_open[Q_EVEN] & ~in_ts_slot_odd;
    elig_c[Q_ODD]  = ~in_ts_fifo_empty[Q_ODD]  & in_ts_gate_open[Q_ODD]  &  in_ts_slot_odd;
    elig_c[Q_RSV]  = ~in_ts_fifo_empty[Q_RSV]  & in_ts_gate_open[Q_RSV]  &  rsv_ok_c;
    elig_c[Q_BE]   = ~in_ts_fifo_empty[Q_BE]   & in_ts_gate_open[Q_BE];
  end

  assign pick_c = pick_queue(elig_c);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    rden_d      = '0;
    beat_d      = beat_q;
    md_wr_d     = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    deduct_en_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (|elig_c) begin
          rden_d      = qid_onehot(pick_c);
          beat_d.qid  = pick_c;
          busy_d      = 1'b1;
          deduct_en_c = (pick_c == Q_RSV);
          state_d     = WAIT_MD;
        end
      end

      // The first cycle here is the rden pulse itself; the buffer answers the next.
      WAIT_MD: begin
        if (rden_q == '0) begin
          if (in_ts_md_wr) begin
            beat_d.md = in_ts_md;
            md_wr_d   = 1'b1;
            state_d   = BUSY;
          end else begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      BUSY: begin
        if (in_ts_tx_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rden_q  <= '0;
      beat_q  <= '0;
      md_wr_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rden_q  <= rden_d;
      beat_q  <= beat_d;
      md_wr_q <= md_wr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign out_ts_q0_rden = rden_q[Q_EVEN];
  assign out_ts_q1_rden = rden_q[Q_ODD];
  assign out_ts_q2_rden = rden_q[Q_RSV];
  assign out_ts_q3_rden = rden_q[Q_BE];
  assign out_ts_md      = beat_q.md;
  assign out_ts_qid     = beat_q.qid;
  assign out_ts_md_wr   = md_wr_q;
  assign out_ts_busy    = busy_q;
  assign out_ts_err     = err_q;

endmodule

// File: tb/tb_ts_sched.sv
// Randomized scoreboard bench for ts_sched: the bench plays metadata buffer and
// output port, predicts selections with a transaction-level model.
module tb_ts_sched;

  localparam int TOKEN_MAX = 512;
  localparam int P_IDLE    = 0;
  localparam int P_ISSUED  = 1;
  localparam int P_WAIT    = 2;
  localparam int P_BUSY    = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_ts_fifo_empty;
  logic [6:0] in_ts_pkt_len;
  logic [3:0] in_ts_gate_open;
  logic       in_ts_slot_odd;
  logic       out_ts_q0_rden, out_ts_q1_rden, out_ts_q2_rden, out_ts_q3_rden;
  logic [7:0] in_ts_md;
  logic       in_ts_md_wr;
  logic [7:0] out_ts_md;
  logic       out_ts_md_wr;
  logic [1:0] out_ts_qid;
  logic       in_ts_tx_done;
  logic       out_ts_busy;
  logic       out_ts_err;

  ts_sched #(.TOKEN_W(16), .TOKEN_RATE(1), .TOKEN_MAX(512)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_ts_fifo_empty (in_ts_fifo_empty),
    .in_ts_pkt_len    (in_ts_pkt_len),
    .in_ts_gate_open  (in_ts_gate_open),
    .in_ts_slot_odd   (in_ts_slot_odd),
    .out_ts_q0_rden   (out_ts_q0_rden),
    .out_ts_q1_rden   (out_ts_q1_rden),
    .out_ts_q2_rden   (out_ts_q2_rden),
    .out_ts_q3_rden   (out_ts_q3_rden),
    .in_ts_md         (in_ts_md),
    .in_ts_md_wr      (in_ts_md_wr),
    .out_ts_md        (out_ts_md),
    .out_ts_md_wr     (out_ts_md_wr),
    .out_ts_qid       (out_ts_qid),
    .in_ts_tx_done    (in_ts_tx_done),
    .out_ts_busy      (out_ts_busy),
    .out_ts_err       (out_ts_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] md;
    logic [1:0] qid;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Scenario controls written by the main sequence, applied by the environment.
  logic [3:0] scen_empty, scen_gate;
  logic       scen_slot;
  logic [6:0] scen_len;
  bit         rand_mode, slot_rand, stray_en, withhold, force_en;
  logic [7:0] force_md;
  int         tx_delay;

  // Reference model state.
  int         m_phase, m_tokens;
  int         m_qid;
  logic [3:0] exp_rden;
  logic       exp_busy, exp_err, after_rst;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_ts_busy === 1'b0) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_idle cycle %0d: busy still 1 after %0d cycles, expected 0", cyc, budget);
  endtask

  // Model: checks this cycle's outputs, then predicts the next cycle from the rules.
  always @(negedge clk) begin : predictor
    logic [3:0] el;
    int         deduct;
    check("rden", {out_ts_q3_rden, out_ts_q2_rden, out_ts_q1_rden, out_ts_q0_rden}, exp_rden);
    check("busy", out_ts_busy, exp_busy);
    check("err", out_ts_err, exp_err);
    check("tokens", dut.u_bucket.tokens, m_tokens);
    if (after_rst) check("outs_after_rst", {out_ts_md, out_ts_qid, out_ts_md_wr}, 0);

    if (!rst_n) begin
      m_phase  = P_IDLE;
      m_tokens = 0;
      exp_rden = 4'h0;
      exp_busy = 1'b0;
      exp_err  = 1'b0;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      deduct    = 0;
      exp_rden  = 4'h0;
      case (m_phase)
        P_IDLE: begin
          el[0] = !in_ts_fifo_empty[0] && in_ts_gate_open[0] && !in_ts_slot_odd;
          el[1] = !in_ts_fifo_empty[1] && in_ts_gate_open[1] &&  in_ts_slot_odd;
          el[2] = !in_ts_fifo_empty[2] && in_ts_gate_open[2] && (m_tokens >= int'(in_ts_pkt_len));
          el[3] = !in_ts_fifo_empty[3] && in_ts_gate_open[3];
          if (el != 4'h0) begin
            m_qid    = el[0] ? 0 : el[1] ? 1 : el[2] ? 2 : 3;
            exp_rden = 4'h1 << m_qid;
            exp_busy = 1'b1;
            m_phase  = P_ISSUED;
            if (m_qid == 2) deduct = int'(in_ts_pkt_len);
          end
        end
        P_ISSUED: m_phase = P_WAIT;
        P_WAIT: begin
          if (in_ts_md_wr) begin
            sb.push_back('{md: in_ts_md, qid: 2'(m_qid), cyc: cyc + 1});
            m_phase = P_BUSY;
          end else begin
            exp_err  = 1'b1;
            exp_busy = 1'b0;
            m_phase  = P_IDLE;
          end
        end
        default: begin
          if (in_ts_tx_done) begin
            exp_busy = 1'b0;
            m_phase  = P_IDLE;
          end
        end
      endcase
      m_tokens = m_tokens + 1 - deduct;
      if (m_tokens > TOKEN_MAX) m_tokens = TOKEN_MAX;
    end
  end

  // Monitor: every forwarded beat must match the next scoreboard entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_ts_md_wr === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL md_wr_spurious cycle %0d: got md_wr=1 md=0x%0h, expected no output", cyc, out_ts_md);
      end else begin
        e = sb.pop_front();
        check("md", out_ts_md, e.md);
        check("qid", out_ts_qid, e.qid);
        check("md_cycle", cyc, e.cyc);
      end
    end
  end

  // Environment: metadata buffer, output port and queue-state stimulus.
  initial begin : env
    bit prev_rden, resp;
    int tx_cnt;
    prev_rden = 1'b0;
    tx_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      resp = prev_rden && !withhold && !(rand_mode && $urandom_range(0, 31) == 0);
      if (prev_rden && withhold) withhold = 1'b0;
      in_ts_md_wr = resp;
      in_ts_md    = resp ? (force_en ? force_md : 8'($urandom)) : 8'h00;
      if (resp) force_en = 1'b0;
      prev_rden = out_ts_q0_rden | out_ts_q1_rden | out_ts_q2_rden | out_ts_q3_rden;

      in_ts_tx_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        in_ts_tx_done = (tx_cnt == 0);
      end else if (stray_en && $urandom_range(0, 15) == 0) begin
        in_ts_tx_done = 1'b1;
      end
      if (out_ts_md_wr) tx_cnt = rand_mode ? int'($urandom_range(1, 6)) : tx_delay;

      if (rand_mode) begin
        in_ts_fifo_empty = 4'($urandom);
        in_ts_gate_open  = 4'($urandom);
        in_ts_pkt_len    = 7'($urandom_range(0, 40));
        if (slot_rand && $urandom_range(0, 7) == 0) scen_slot = ~scen_slot;
      end else begin
        in_ts_fifo_empty = scen_empty;
        in_ts_gate_open  = scen_gate;
        in_ts_pkt_len    = scen_len;
      end
      in_ts_slot_odd = scen_slot;
    end
  end

  initial begin : main
    int t0, t_rel;
    clk = 1'b0;
    rst_n = 1'b0;
    scen_empty = 4'h0; scen_gate = 4'hF; scen_slot = 1'b0; scen_len = 7'd20;
    rand_mode = 0; slot_rand = 0; stray_en = 0; withhold = 0; force_en = 0;
    force_md = 8'h00; tx_delay = 5;
    in_ts_fifo_empty = 4'h0; in_ts_gate_open = 4'hF; in_ts_slot_odd = 1'b0;
    in_ts_pkt_len = 7'd20; in_ts_md = 8'h00; in_ts_md_wr = 1'b0; in_ts_tx_done = 1'b0;
    m_phase = P_IDLE; m_tokens = 0; m_qid = 0;
    exp_rden = 4'h0; exp_busy = 1'b0; exp_err = 1'b0; after_rst = 1'b0;

    // Reset held with every queue ready.
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    // All queues ready: even slot then odd slot, then random occupancy.
    repeat (40) @(posedge clk);
    scen_slot = 1'b1;
    repeat (40) @(posedge clk);
    rand_mode = 1; scen_slot = 1'b0;
    repeat (150) @(posedge clk);
    scen_slot = 1'b1;
    repeat (150) @(posedge clk);
    rand_mode = 0; scen_empty = 4'hF;
    wait_idle(40);

    // Latency: q3 alone, buffer returns 0xA5.
    force_md = 8'hA5; force_en = 1; scen_empty = 4'b0111; tx_delay = 5;
    t0 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_ts_q3_rden) begin t0 = cyc; break; end
    end
    check("lat_rden_seen", (t0 >= 0), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_ts_md_wr) break;
    end
    scen_empty = 4'hF;
    check("lat_cycles", cyc - t0, 2);
    check("lat_md", out_ts_md, 8'hA5);
    check("lat_qid", out_ts_qid, 3);
    @(negedge clk);
    check("lat_busy_hold", out_ts_busy, 1);
    wait_idle(40);

    // Shaper: only q2 ready, pkt_len 20, from reset.
    @(posedge clk); #1 rst_n = 1'b0;
    scen_empty = 4'b1011; scen_len = 7'd20; tx_delay = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    t_rel = cyc;
    t0 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_ts_q2_rden) begin t0 = cyc; break; end
    end
    check("shaper_first", t0 - t_rel, 21);
    check("shaper_tokens_after", dut.u_bucket.tokens, 1);
    t_rel = t0;
    t0 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_ts_q2_rden) begin t0 = cyc; break; end
    end
    check("shaper_second", t0 - t_rel, 20);

    // Saturation: long idle from reset.
    @(posedge clk); #1 rst_n = 1'b0; scen_empty = 4'hF;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("tokens_saturated", dut.u_bucket.tokens, TOKEN_MAX);

    // Missing metadata: error is sticky and the scheduler returns to idle.
    withhold = 1; scen_empty = 4'b0111;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_ts_err) break;
    end
    scen_empty = 4'hF;
    check("err_set", out_ts_err, 1);
    check("err_busy_clear", out_ts_busy, 0);
    repeat (5) @(negedge clk);
    check("err_sticky", out_ts_err, 1);

    // Random traffic with dropped metadata and stray tx_done pulses.
    rand_mode = 1; slot_rand = 1; stray_en = 1;
    repeat (3000) @(posedge clk);
    rand_mode = 0; stray_en = 0; scen_empty = 4'h0; tx_delay = 8;

    // Reset while a packet is in flight.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_ts_md_wr) break;
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_outs", {out_ts_q3_rden, out_ts_q2_rden, out_ts_q1_rden, out_ts_q0_rden,
                          out_ts_md, out_ts_qid, out_ts_md_wr, out_ts_busy, out_ts_err}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);

    scen_empty = 4'hF;
    wait_idle(40);
    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
